// File: rtl/pulse_meter.sv
// pulse_meter: measures high time and period of an asynchronous pulse train; PULSE_METER_MINMAX_EN adds min/max period tracking
module pulse_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             sat,
  output logic             overrun,
  output logic [7:0]       pulse_count
`ifdef PULSE_METER_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
`endif
);
  localparam logic [CNT_W-1:0] cnt_max = '1;
  localparam logic [CNT_W-1:0] cnt_one = CNT_W'(1);
  typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH, LOW} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync, primed;
  logic s, s_d, rise, fall, done, accept;
  logic [CNT_W-1:0] hc, pc, hc_nx, pc_nx, hc_inc, pc_inc;
  logic hc_full, pc_full, sf, sf_nx;
  assign s      = sync[SYNC_STAGES-1];
  assign rise   = s & ~s_d;
  assign fall   = ~s & s_d;
  assign hc_full = hc == cnt_max;
  assign pc_full = pc == cnt_max;
  assign hc_inc = hc_full ? hc : hc + 1'b1;
  assign pc_inc = pc_full ? pc : pc + 1'b1;
  assign accept = done & (~meas_valid | meas_ready);
  // synchronizer chain; primed marks when s reflects a real sample rather than reset zeros
  always_ff @(posedge clock)
    if (reset) begin
      sync   <= '0;
      primed <= '0;
      s_d    <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], signal};
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
      s_d    <= s;
    end
  // state and measurement counters
  always_ff @(posedge clock)
    if (reset) begin
      state <= ARM;
      hc    <= '0;
      pc    <= '0;
      sf    <= 1'b0;
    end else begin
      state <= state_nx;
      hc    <= hc_nx;
      pc    <= pc_nx;
      sf    <= sf_nx;
    end
  // next state and counter updates; saturating increments latch the sat flag
  always_comb begin
    state_nx = state;
    hc_nx    = hc;
    pc_nx    = pc;
    sf_nx    = sf;
    done     = 1'b0;
    case (state)
      ARM: state_nx = (primed[SYNC_STAGES-1] && !s) ? WAIT_RISE : ARM;
      WAIT_RISE:
        if (rise) begin
          state_nx = HIGH;
          hc_nx    = cnt_one;
          pc_nx    = cnt_one;
          sf_nx    = 1'b0;
        end
      HIGH: begin
        pc_nx    = pc_inc;
        sf_nx    = sf | pc_full | (~fall & hc_full);
        hc_nx    = fall ? hc : hc_inc;
        state_nx = fall ? LOW : HIGH;
      end
      LOW:
        if (rise) begin
          done     = 1'b1;
          state_nx = HIGH;
          hc_nx    = cnt_one;
          pc_nx    = cnt_one;
          sf_nx    = 1'b0;
        end else begin
          pc_nx = pc_inc;
          sf_nx = sf | pc_full;
        end
    endcase
  end
  // result registers and valid/ready handshake; a completion that finds the port stalled is dropped
  always_ff @(posedge clock)
    if (reset) begin
      meas_valid  <= 1'b0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      sat         <= 1'b0;
      overrun     <= 1'b0;
      pulse_count <= '0;
    end else if (accept) begin
      meas_valid  <= 1'b1;
      high_cnt    <= hc;
      period_cnt  <= pc;
      sat         <= sf;
      pulse_count <= pulse_count + 8'd1;
    end else if (done) begin
      overrun <= 1'b1;
    end else if (meas_ready) begin
      meas_valid <= 1'b0;
    end
`ifdef PULSE_METER_MINMAX_EN
  // period extremes track every completion, dropped ones included
  always_ff @(posedge clock)
    if (reset) begin
      min_period <= '1;
      max_period <= '0;
    end else if (done) begin
      min_period <= (pc < min_period) ? pc : min_period;
      max_period <= (pc > max_period) ? pc : max_period;
    end
`endif
endmodule
